// File: rtl/axis_frame_arbiter.sv
// axis_frame_arbiter
// Shares one AXI4-Stream sink between S_COUNT sources. Arbitration happens at
// frame granularity: a granted source keeps the sink until its tlast beat has
// been accepted. The output is a single register stage. m_axis_tid carries the
// index of the source that produced each beat.
//
// Build option:
//   AXIS_ARB_FIXED_PRIO_EN  defined   -> lowest-index requester always wins,
//                                        no round-robin pointer exists
//                           undefined -> round-robin starting at rr_ptr
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   s_axis_tdata      S_COUNT*DATA_WIDTH input data, stream i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_axis_tvalid     per-stream valid
//   s_axis_tready     per-stream ready (only the granted stream can be high)
//   s_axis_tlast      per-stream end of frame
//   s_axis_tuser      S_COUNT*USER_WIDTH per-stream user
//   m_axis_tdata      output data
//   m_axis_tvalid     output valid
//   m_axis_tready     output ready
//   m_axis_tlast      output end of frame
//   m_axis_tuser      output user
//   m_axis_tid        source index of the current output beat
//   grant_valid       a frame is in progress
//   grant_index       index of the granted (or most recently granted) source

module axis_frame_arbiter #(
    parameter int S_COUNT    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int USER_WIDTH = 1,
    localparam int IDX_WIDTH = $clog2(S_COUNT)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_COUNT-1:0]            s_axis_tvalid,
    output logic [S_COUNT-1:0]            s_axis_tready,
    input  logic [S_COUNT-1:0]            s_axis_tlast,
    input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [USER_WIDTH-1:0]         m_axis_tuser,
    output logic [IDX_WIDTH-1:0]          m_axis_tid,
    output logic                          grant_valid,
    output logic [IDX_WIDTH-1:0]          grant_index
);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t                state;
    logic [IDX_WIDTH-1:0]  winner;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_valid;
    logic                  sel_last;
    logic [USER_WIDTH-1:0] sel_user;
    logic                  out_room;
    logic                  beat_accept;

`ifndef AXIS_ARB_FIXED_PRIO_EN
    logic [IDX_WIDTH-1:0]  rr_ptr;
    logic [IDX_WIDTH-1:0]  next_ptr;
`endif

    // The output register can take a new beat when it is empty or being drained.
    assign out_room    = m_axis_tready | ~m_axis_tvalid;
    assign beat_accept = (state == ACTIVE) & sel_valid & out_room;

    // Select the granted stream's sideband with constant-index slices.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_user  = '0;
        for (int i = 0; i < S_COUNT; i++) begin
            if (grant_index == IDX_WIDTH'(i)) begin
                sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_valid = s_axis_tvalid[i];
                sel_last  = s_axis_tlast[i];
                sel_user  = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
            end
        end
    end

    always_comb begin
        s_axis_tready = '0;
        for (int i = 0; i < S_COUNT; i++) begin
            if (state == ACTIVE && grant_index == IDX_WIDTH'(i)) begin
                s_axis_tready[i] = out_room;
            end
        end
    end

    // Winner selection. The round-robin search "first requester at or after
    // rr_ptr, wrapping" is split into two scans: the lowest requester with
    // index >= rr_ptr, falling back to the lowest requester overall.
    always_comb begin
        logic [IDX_WIDTH-1:0] lowest_any;
`ifndef AXIS_ARB_FIXED_PRIO_EN
        logic [IDX_WIDTH-1:0] lowest_upper;
        logic                 found_upper;
        lowest_upper = '0;
        found_upper  = 1'b0;
`endif
        lowest_any = '0;
        for (int i = S_COUNT - 1; i >= 0; i--) begin
            if (s_axis_tvalid[i]) begin
                lowest_any = IDX_WIDTH'(i);
            end
`ifndef AXIS_ARB_FIXED_PRIO_EN
            if (s_axis_tvalid[i] && IDX_WIDTH'(i) >= rr_ptr) begin
                lowest_upper = IDX_WIDTH'(i);
                found_upper  = 1'b1;
            end
`endif
        end
`ifndef AXIS_ARB_FIXED_PRIO_EN
        winner = found_upper ? lowest_upper : lowest_any;
`else
        winner = lowest_any;
`endif
    end

`ifndef AXIS_ARB_FIXED_PRIO_EN
    assign next_ptr = (grant_index == IDX_WIDTH'(S_COUNT - 1)) ? '0
                                                               : grant_index + IDX_WIDTH'(1);
`endif

    // Grant FSM and output register. A beat accepted in the same cycle the
    // register drains simply overwrites it, giving full throughput in a frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            grant_valid   <= 1'b0;
            grant_index   <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
            m_axis_tid    <= '0;
`ifndef AXIS_ARB_FIXED_PRIO_EN
            rr_ptr        <= '0;
`endif
        end else begin
            if (beat_accept) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= sel_data;
                m_axis_tlast  <= sel_last;
                m_axis_tuser  <= sel_user;
                m_axis_tid    <= grant_index;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (|s_axis_tvalid) begin
                        state       <= ACTIVE;
                        grant_valid <= 1'b1;
                        grant_index <= winner;
                    end
                end
                ACTIVE: begin
                    if (beat_accept && sel_last) begin
                        state       <= IDLE;
                        grant_valid <= 1'b0;
`ifndef AXIS_ARB_FIXED_PRIO_EN
                        rr_ptr      <= next_ptr;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
